// File: rtl/frame_fetch_if.sv
// ---------------------------------------------------------------------------
// frame_fetch_if
// Groups the frame-feed handshake, the src_rom read port and the outgoing
// pixel stream of frame_fetch_ctrl into one bundle.
//
// Signals (directions as seen from the controller, modport master):
//   go        in   start-of-frame pulse
//   ready     out  one-cycle "frame fully delivered" pulse
//   busy      out  high from accepted go through the ready pulse
//   rom_en    out  src_rom read enable
//   rom_addr  out  src_rom read address
//   rom_data  in   src_rom read data, valid one cycle after rom_en
//   px_data   out  pixel value
//   px_valid  out  pixel valid
//   px_ready  in   downstream accept
//   px_sof    out  first pixel of frame
//   px_eol    out  last pixel of a row
//   px_eof    out  last pixel of frame
//
// The slave modport is the environment side: the feed logic, the ROM and
// the downstream line buffer.
// ---------------------------------------------------------------------------
interface frame_fetch_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10
);
  logic              go;
  logic              ready;
  logic              busy;
  logic              rom_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic [DATA_W-1:0] px_data;
  logic              px_valid;
  logic              px_ready;
  logic              px_sof;
  logic              px_eol;
  logic              px_eof;

  modport master (
    input  go, rom_data, px_ready,
    output ready, busy, rom_en, rom_addr,
           px_data, px_valid, px_sof, px_eol, px_eof
  );

  modport slave (
    output go, rom_data, px_ready,
    input  ready, busy, rom_en, rom_addr,
           px_data, px_valid, px_sof, px_eol, px_eof
  );
endinterface

// File: rtl/frame_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// frame_fetch_ctrl
// On a one-cycle go pulse, reads one IMG_W x IMG_H frame from src_rom in
// raster order and streams it out as a valid/ready pixel stream with
// sof/eol/eof markers. Pulses ready once the eof pixel has been accepted.
//
// Ports:
//   clk   system clock, all logic on the rising edge
//   rst   synchronous active-high reset; aborts any frame in progress
//   bus   frame_fetch_if.master: go/ready/busy handshake, src_rom read
//         port (rom_en/rom_addr/rom_data) and the pixel stream
//         (px_data/px_valid/px_ready/px_sof/px_eol/px_eof)
//
// Datapath:
//   A word read from the ROM is "in flight" during the cycle after rom_en
//   and is presented on the stream that same cycle when the output buffer
//   is empty (pass-through). If it is not accepted it drops into a 2-entry
//   buffer; the buffer head is always presented first. A new read is only
//   issued when buffered + in-flight words leave room for it, so the
//   buffer can never overflow and nothing is dropped or duplicated.
//   The sof/eol/eof markers are computed when the address is issued and
//   travel with the word through the pipeline and the buffer.
// ---------------------------------------------------------------------------
module frame_fetch_ctrl #(
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10
) (
  input  logic           clk,
  input  logic           rst,
  frame_fetch_if.master  bus
);

  localparam int TOTAL = IMG_W * IMG_H;
  localparam int CW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RWID  = $clog2(IMG_H + 1);
  localparam int AW1   = ADDR_W + 1;
  // buffered word = pixel data plus {sof, eol, eof}
  localparam int WW    = DATA_W + 3;

  localparam logic [CW-1:0]   COL_LAST = CW'(IMG_W - 1);
  localparam logic [RWID-1:0] ROW_LAST = RWID'(IMG_H - 1);
  localparam logic [AW1-1:0]  ADDR_END = AW1'(TOTAL);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // control state
  state_t            state_q, state_d;
  logic              rom_en_q, rom_en_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [AW1-1:0]    rd_addr_q, rd_addr_d;     // next address to issue
  logic [CW-1:0]     col_q, col_d;             // column of next address
  logic [RWID-1:0]   row_q, row_d;             // row of next address
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;

  // markers of the read issued this cycle / of the word arriving this cycle
  logic [2:0]        iss_flags_q, iss_flags_d;
  logic [2:0]        pend_flags_q, pend_flags_d;
  logic              pend_q, pend_d;           // a ROM word arrives this cycle

  // 2-entry output buffer, entry 0 is the head
  logic [WW-1:0]     buf_q [2];
  logic [WW-1:0]     buf_d [2];
  logic [1:0]        cnt_q, cnt_d;

  // combinational helpers
  logic [WW-1:0]     in_word;
  logic [WW-1:0]     head_word;
  logic              px_valid;
  logic              xfer;
  logic              pop;
  logic              push;
  logic [1:0]        wr_idx;
  logic              issue;
  logic [AW1-1:0]    iss_a;
  logic [CW-1:0]     iss_c;
  logic [RWID-1:0]   iss_r;

  // -------------------------------------------------------------------------
  // Output stream and buffer bookkeeping
  // -------------------------------------------------------------------------
  always_comb begin
    in_word   = {bus.rom_data, pend_flags_q};
    px_valid  = (cnt_q != 2'd0) | pend_q;
    head_word = (cnt_q != 2'd0) ? buf_q[0] : in_word;
    xfer      = px_valid & bus.px_ready;
    pop       = xfer & (cnt_q != 2'd0);
    // the arriving word is stored unless it went straight out this cycle
    push      = pend_q & ~(xfer & (cnt_q == 2'd0));
    wr_idx    = cnt_q - {1'b0, pop};

    buf_d[0] = buf_q[0];
    buf_d[1] = buf_q[1];
    if (pop) begin
      buf_d[0] = buf_q[1];
    end
    if (push) begin
      if (wr_idx == 2'd0) begin
        buf_d[0] = in_word;
      end else begin
        buf_d[1] = in_word;
      end
    end
    cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
  end

  assign bus.px_valid = px_valid;
  assign bus.px_data  = px_valid ? head_word[WW-1:3] : '0;
  assign bus.px_sof   = px_valid & head_word[2];
  assign bus.px_eol   = px_valid & head_word[1];
  assign bus.px_eof   = px_valid & head_word[0];
  assign bus.rom_en   = rom_en_q;
  assign bus.rom_addr = rom_addr_q;
  assign bus.ready    = ready_q;
  assign bus.busy     = busy_q;

  // -------------------------------------------------------------------------
  // Sequencer and read issue
  // -------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    rom_en_d     = 1'b0;
    rom_addr_d   = rom_addr_q;
    rd_addr_d    = rd_addr_q;
    col_d        = col_q;
    row_d        = row_q;
    iss_flags_d  = iss_flags_q;
    ready_d      = 1'b0;
    busy_d       = busy_q;
    // the word read this cycle arrives next cycle, markers follow it
    pend_d       = rom_en_q;
    pend_flags_d = iss_flags_q;

    issue = 1'b0;
    iss_a = rd_addr_q;
    iss_c = col_q;
    iss_r = row_q;

    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (bus.go) begin
          state_d = S_FETCH;
          busy_d  = 1'b1;
          issue   = 1'b1;
          iss_a   = '0;
          iss_c   = '0;
          iss_r   = '0;
        end
      end
      S_FETCH: begin
        if (rd_addr_q == ADDR_END) begin
          state_d = S_DRAIN;
        end else if ((cnt_d + {1'b0, rom_en_q}) < 2'd2) begin
          // room for the returning word even if nothing drains meanwhile
          issue = 1'b1;
        end
      end
      S_DRAIN: begin
        if (xfer && head_word[0]) begin
          state_d = S_DONE;
          ready_d = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    if (issue) begin
      rom_en_d    = 1'b1;
      rom_addr_d  = iss_a[ADDR_W-1:0];
      rd_addr_d   = iss_a + 1'b1;
      iss_flags_d = {(iss_r == '0) && (iss_c == '0),
                     (iss_c == COL_LAST),
                     (iss_r == ROW_LAST) && (iss_c == COL_LAST)};
      if (iss_c == COL_LAST) begin
        col_d = '0;
        row_d = iss_r + 1'b1;
      end else begin
        col_d = iss_c + 1'b1;
        row_d = iss_r;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      rom_en_q     <= 1'b0;
      rom_addr_q   <= '0;
      rd_addr_q    <= '0;
      col_q        <= '0;
      row_q        <= '0;
      ready_q      <= 1'b0;
      busy_q       <= 1'b0;
      iss_flags_q  <= '0;
      pend_flags_q <= '0;
      pend_q       <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      rom_en_q     <= rom_en_d;
      rom_addr_q   <= rom_addr_d;
      rd_addr_q    <= rd_addr_d;
      col_q        <= col_d;
      row_q        <= row_d;
      ready_q      <= ready_d;
      busy_q       <= busy_d;
      iss_flags_q  <= iss_flags_d;
      pend_flags_q <= pend_flags_d;
      pend_q       <= pend_d;
      cnt_q        <= cnt_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_buf
      always_ff @(posedge clk) begin
        if (rst) begin
          buf_q[gi] <= '0;
        end else begin
          buf_q[gi] <= buf_d[gi];
        end
      end
    end
  endgenerate

endmodule
